// File: rtl/mem_resp_pkg.sv
// Shared definitions for the MAR/MBR memory responder: default bus geometry
// and the responder FSM encoding, also used by the CPU top.
package mem_resp_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 8;
  localparam int DEF_DEPTH = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

  // Index width for a DEPTH-entry array, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-to-memory bus: 4-phase req/ack access channel plus the side-band preload port.
interface mem_responder_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  modport master (
    output req, we, addr, wdata, load_en, load_addr, load_data,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, load_en, load_addr, load_data,
    output ack, rdata, err, busy
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DW word store with a single write port shared by the preload and bus
// paths, and an asynchronous read port. Contents are never reset.
module mem_array #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int IW    = 4
) (
  input  logic          clock,
  input  logic          i_load_en,
  input  logic [IW-1:0] i_load_addr,
  input  logic [DW-1:0] i_load_data,
  input  logic          i_bus_we,
  input  logic [IW-1:0] i_bus_addr,
  input  logic [DW-1:0] i_bus_data,
  input  logic [IW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_we;
  logic [IW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  // A bus write can only coincide with a load when the responder has no wait
  // states; the bus access is the later one in program order, so it wins.
  assign w_we    = i_bus_we | i_load_en;
  assign w_waddr = i_bus_we ? i_bus_addr : i_load_addr;
  assign w_wdata = i_bus_we ? i_bus_data : i_load_data;

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU MAR/MBR bus with programmable wait states.
// Define MEM_RANGE_CHECK_EN to report out-of-range accesses on err.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic          clock,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int          IW      = idx_width(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [3:0]  WS_C    = 4'(WAIT_STATES);

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_idle;
  logic          w_start;
  logic          w_do_access;
  logic          w_acc_we;
  logic [AW-1:0] w_acc_addr;
  logic [DW-1:0] w_acc_wdata;
  logic          w_acc_inr;
  logic          w_load_ok;
  logic          w_fwd;
  logic          w_bus_mem_we;
  logic [DW-1:0] w_mem_rdata;
  logic [DW-1:0] w_rd_val;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_idle && bus.req;

  // The access fires on the edge where the counter reaches zero; with no wait
  // states that is the capture edge itself, so the live bus fields are used.
  assign w_do_access = (w_start && (WAIT_STATES == 0)) ||
                       ((r_state == ST_BUSY) && (r_cnt == 4'd1));

  assign w_acc_we    = w_idle ? bus.we    : r_we;
  assign w_acc_addr  = w_idle ? bus.addr  : r_addr;
  assign w_acc_wdata = w_idle ? bus.wdata : r_wdata;
  assign w_acc_inr   = ({1'b0, w_acc_addr} < DEPTH_C);

  assign w_load_ok    = w_idle && bus.load_en && ({1'b0, bus.load_addr} < DEPTH_C);
  assign w_bus_mem_we = w_do_access && w_acc_we && w_acc_inr;

  // Only reachable with zero wait states: a read captured together with a load
  // to the same word must still observe the freshly loaded value.
  assign w_fwd    = w_load_ok && (bus.load_addr == w_acc_addr);
  assign w_rd_val = !w_acc_inr ? '0 : (w_fwd ? bus.load_data : w_mem_rdata);

  mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem_array (
    .clock       (clock),
    .i_load_en   (w_load_ok),
    .i_load_addr (bus.load_addr[IW-1:0]),
    .i_load_data (bus.load_data),
    .i_bus_we    (w_bus_mem_we),
    .i_bus_addr  (w_acc_addr[IW-1:0]),
    .i_bus_data  (w_acc_wdata),
    .i_raddr     (w_acc_addr[IW-1:0]),
    .o_rdata     (w_mem_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_cnt_next   = WS_C;
          w_state_next = (WAIT_STATES == 0) ? ST_ACK : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus.req) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_start) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_do_access && !w_acc_we) begin
        r_rdata <= w_rd_val;
      end
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_do_access) begin
      r_err <= ~w_acc_inr;
    end else if ((r_state == ST_ACK) && !bus.req) begin
      r_err <= 1'b0;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ack   = (r_state == ST_ACK);
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (1, 0 and 4 wait states);
// stimulus pushes expected responses, a negedge monitor checks each ack rise.
module tb_mem_responder;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst0, rst4;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic prev_ack [3];
  logic [7:0] sweep_exp [9] = '{8'h10, 8'h11, 8'h12, 8'hA5, 8'h14,
                                8'h3C, 8'h16, 8'h5A, 8'h18};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.DW(8), .AW(8)) bus_a ();
  mem_responder_if #(.DW(8), .AW(8)) bus_b ();
  mem_responder_if #(.DW(8), .AW(8)) bus_c ();

  mem_responder #(.DW(8), .AW(8), .DEPTH(9), .WAIT_STATES(1)) u_ws1 (
    .clock (clk), .reset (rst1), .bus (bus_a));
  mem_responder #(.DW(8), .AW(8), .DEPTH(9), .WAIT_STATES(0)) u_ws0 (
    .clock (clk), .reset (rst0), .bus (bus_b));
  mem_responder #(.DW(8), .AW(8), .DEPTH(9), .WAIT_STATES(4)) u_ws4 (
    .clock (clk), .reset (rst4), .bus (bus_c));

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic set_req(input int k, input logic r, input logic we,
                         input logic [7:0] a, input logic [7:0] wd);
    case (k)
      0: begin bus_a.req = r; bus_a.we = we; bus_a.addr = a; bus_a.wdata = wd; end
      1: begin bus_b.req = r; bus_b.we = we; bus_b.addr = a; bus_b.wdata = wd; end
      default: begin bus_c.req = r; bus_c.we = we; bus_c.addr = a; bus_c.wdata = wd; end
    endcase
  endtask

  task automatic set_load(input int k, input logic en, input logic [7:0] a, input logic [7:0] d);
    case (k)
      0: begin bus_a.load_en = en; bus_a.load_addr = a; bus_a.load_data = d; end
      1: begin bus_b.load_en = en; bus_b.load_addr = a; bus_b.load_data = d; end
      default: begin bus_c.load_en = en; bus_c.load_addr = a; bus_c.load_data = d; end
    endcase
  endtask

  task automatic sample(input int k, output logic ac, output logic [7:0] rd,
                        output logic e, output logic b);
    case (k)
      0: begin ac = bus_a.ack; rd = bus_a.rdata; e = bus_a.err; b = bus_a.busy; end
      1: begin ac = bus_b.ack; rd = bus_b.rdata; e = bus_b.err; b = bus_b.busy; end
      default: begin ac = bus_c.ack; rd = bus_c.rdata; e = bus_c.err; b = bus_c.busy; end
    endcase
  endtask

  task automatic push(input int k, input exp_t x);
    case (k)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic pop(input int k, output bit got, output exp_t x);
    got = 1'b0;
    x   = '{rdata: 8'h00, err: 1'b0, lat: 0, issue: 0};
    case (k)
      0: if (q0.size() > 0) begin x = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin x = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin x = q2.pop_front(); got = 1'b1; end
    endcase
  endtask

  // Monitor: every rising ack pops one expected response.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic       ac, e, b;
      logic [7:0] rd;
      exp_t       x;
      bit         got;
      sample(k, ac, rd, e, b);
      if (ac && (prev_ack[k] === 1'b0)) begin
        pop(k, got, x);
        n_tests++;
        if (!got) begin
          n_fail++;
          $display("FAIL unexpected_ack dut%0d: ack=1 with nothing pending, required 0", k);
        end else begin
          $display("[TB] dut%0d rsp rdata=%02h err=%0b lat=%0d", k, rd, e, cyc - x.issue);
          chk("rsp_rdata", 32'(rd), 32'(x.rdata));
          chk("rsp_err", 32'(e), 32'(x.err));
          chk("rsp_latency", 32'(cyc - x.issue), 32'(x.lat));
        end
      end
      prev_ack[k] <= ac;
    end
  end

  task automatic load(input int k, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    set_load(k, 1'b1, a, d);
    @(posedge clk); #1;
    set_load(k, 1'b0, 8'h00, 8'h00);
  endtask

  // One full 4-phase access; request fields are scrambled right after capture.
  task automatic access(input int k, input logic we, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input int hold,
                        input bit ld = 1'b0, input logic [7:0] ld_a = 8'h00,
                        input logic [7:0] ld_d = 8'h00, input bit busy_ld = 1'b0);
    exp_t       x;
    logic       ac, e, b;
    logic [7:0] rd;
    int         t;
    @(posedge clk); #1;
    set_req(k, 1'b1, we, a, wd);
    if (ld) set_load(k, 1'b1, ld_a, ld_d);
    x.rdata = exp_rd;
    x.err   = RC && (a >= 8'd9);
    x.lat   = ws_of(k);
    x.issue = cyc + 1;
    push(k, x);
    @(posedge clk); #1;
    set_req(k, 1'b1, ~we, ~a, ~wd);
    set_load(k, 1'b0, 8'h00, 8'h00);
    t  = 0;
    ac = 1'b0;
    while (!ac && t < 40) begin
      @(negedge clk);
      sample(k, ac, rd, e, b);
      t++;
    end
    n_tests++;
    if (!ac) begin
      n_fail++;
      $display("FAIL ack_timeout dut%0d: ack=0 after %0d cycles, required 1", k, t);
      set_req(k, 1'b0, 1'b0, 8'h00, 8'h00);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (busy_ld) set_load(k, (h == 0), 8'd2, 8'hEE);
      @(negedge clk);
      sample(k, ac, rd, e, b);
      chk("ack_held", 32'(ac), 32'd1);
      chk("rdata_held", 32'(rd), 32'(exp_rd));
    end
    @(posedge clk); #1;
    set_req(k, 1'b0, 1'b0, 8'h00, 8'h00);
    set_load(k, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    sample(k, ac, rd, e, b);
    chk("ack_fall", 32'(ac), 32'd0);
    chk("busy_fall", 32'(b), 32'd0);
    chk("err_idle", 32'(e), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ac, e, b;
    logic [7:0] rd;
    rst1 = 1'b1; rst0 = 1'b1; rst4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b0, 1'b0, 8'h00, 8'h00);
      set_load(k, 1'b0, 8'h00, 8'h00);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sample(k, ac, rd, e, b);
      chk("reset_ack", 32'(ac), 32'd0);
      chk("reset_rdata", 32'(rd), 32'd0);
      chk("reset_err", 32'(e), 32'd0);
      chk("reset_busy", 32'(b), 32'd0);
    end
    @(posedge clk); #1;
    rst1 = 1'b0; rst0 = 1'b0; rst4 = 1'b0;

    // One wait state: preload, read, write/readback, held req, load+req, range.
    for (int i = 0; i < 9; i++) load(0, 8'(i), 8'(8'h10 + i));
    load(0, 8'd3, 8'hA5);
    access(0, 1'b0, 8'd3, 8'h00, 8'hA5, 2);
    access(0, 1'b1, 8'd5, 8'h3C, 8'hA5, 0);
    access(0, 1'b0, 8'd5, 8'h00, 8'h3C, 0);
    access(0, 1'b0, 8'd3, 8'h00, 8'hA5, 10, 1'b0, 8'h00, 8'h00, 1'b1);
    access(0, 1'b0, 8'd8, 8'h00, 8'h18, 0);
    access(0, 1'b0, 8'd7, 8'h00, 8'h5A, 0, 1'b1, 8'd7, 8'h5A);
    load(0, 8'h83, 8'hEE);
    access(0, 1'b1, 8'd9, 8'h77, 8'h5A, 1);
    access(0, 1'b0, 8'd9, 8'h00, 8'h00, 1);
    access(0, 1'b1, 8'h85, 8'h99, 8'h00, 0);
    access(0, 1'b0, 8'd5, 8'h00, 8'h3C, 0);
    for (int i = 0; i < 9; i++) access(0, 1'b0, 8'(i), 8'h00, sweep_exp[i], 0);

    // Zero wait states.
    load(1, 8'd0, 8'h11);
    access(1, 1'b0, 8'd0, 8'h00, 8'h11, 1);
    access(1, 1'b1, 8'd4, 8'h4D, 8'h11, 0);
    access(1, 1'b0, 8'd4, 8'h00, 8'h4D, 0);
    access(1, 1'b0, 8'd9, 8'h00, 8'h00, 0);

    // Four wait states with a reset in the second BUSY cycle of a write.
    load(2, 8'd3, 8'hA5);
    access(2, 1'b0, 8'd3, 8'h00, 8'hA5, 0);
    @(posedge clk); #1;
    set_req(2, 1'b1, 1'b1, 8'd3, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample(2, ac, rd, e, b);
    chk("busy_before_reset", 32'(b), 32'd1);
    chk("ack_before_reset", 32'(ac), 32'd0);
    rst4 = 1'b1;
    #1;
    sample(2, ac, rd, e, b);
    chk("abort_ack", 32'(ac), 32'd0);
    chk("abort_rdata", 32'(rd), 32'd0);
    chk("abort_busy", 32'(b), 32'd0);
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst4 = 1'b0;
    access(2, 1'b0, 8'd3, 8'h00, 8'hA5, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
